seg_scan_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 48 ++++
 rtl/seg_scan_driver.sv | 120 ++++++++++++
 tb/tb_seg_scan_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared display-code constants and conversion FSM encoding for the
// seven-segment path; also consumed by seg_mapping downstream.
package seg_pkg;

  localparam logic [4:0] SEG_BLANK = 5'd16;
  localparam logic [4:0] SEG_MINUS = 5'd17;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    FORMAT
  } state_t;

  // BCD nibble to display code, optionally suppressed to a blank glyph
  function automatic logic [4:0] dec_digit(input logic [3:0] nib, input logic suppress);
    return suppress ? SEG_BLANK : {1'b0, nib};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 8-bit double-dabble: one add-3/shift step per clock, eight
// steps after start, done high during the cycle of the final step.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_bin,
  output logic       o_done,
  output logic [3:0] o_hundreds,
  output logic [3:0] o_tens,
  output logic [3:0] o_ones
);

  logic [19:0] r_sr;
  logic [2:0]  r_cnt;
  logic        r_active;
  logic [19:0] w_adj;

  always_comb begin
    w_adj = r_sr;
    for (int unsigned i = 0; i < 3; i++) begin
      w_adj[8 + 4*i +: 4] = (r_sr[8 + 4*i +: 4] >= 4'd5) ? r_sr[8 + 4*i +: 4] + 4'd3
                                                          : r_sr[8 + 4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr     <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_sr     <= {12'd0, i_bin};
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_sr  <= {w_adj[18:0], 1'b0};
      r_cnt <= r_cnt + 3'd1;
      if (r_cnt == 3'd7) r_active <= 1'b0;
    end
  end

  assign o_done     = r_active && (r_cnt == 3'd7);
  assign o_hundreds = r_sr[19:16];
  assign o_tens     = r_sr[15:12];
  assign o_ones     = r_sr[11:8];

endmodule

// File: rtl/seg_scan_driver.sv
// Captures an 8-bit ALU result, formats it as signed decimal or hex into
// four display codes, and time-multiplexes them onto one digit bus.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic       hex_mode,
  input  logic       load,
  output logic       busy,
  output logic [3:0] an,
  output logic [4:0] digit_holder
);

  localparam int unsigned      PW         = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0]    PRESC_MAX  = PW'(REFRESH_DIV - 1);

  state_t          r_state, w_next;
  logic [7:0]      r_value;
  logic            r_hex;
  logic [3:0][4:0] r_disp;
  logic [3:0][4:0] w_fmt_disp;
  logic            w_accept, w_start, w_fmt;
  logic [7:0]      w_mag;
  logic            w_done;
  logic [3:0]      w_h, w_t, w_o;
  logic [PW-1:0]   r_presc;
  logic [1:0]      r_idx;
  logic [3:0]      r_an;
  logic [4:0]      r_digit;

  // Magnitude of the live input, so conversion starts on the accepting edge
  assign w_mag = value[7] ? (~value + 8'd1) : value;

  bin2bcd_seq u_bcd (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_start),
    .i_bin     (w_mag),
    .o_done    (w_done),
    .o_hundreds(w_h),
    .o_tens    (w_t),
    .o_ones    (w_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (load)   w_next = hex_mode ? FORMAT : CONVERT;
      CONVERT: if (w_done) w_next = FORMAT;
      FORMAT:              w_next = IDLE;
      default:             w_next = IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == IDLE) && load;
    w_start  = w_accept && !hex_mode;
    w_fmt    = (r_state == FORMAT);
    busy     = (r_state != IDLE);
  end

  always_comb begin
    w_fmt_disp = {4{SEG_BLANK}};
    if (r_hex) begin
      w_fmt_disp[1] = {1'b0, r_value[7:4]};
      w_fmt_disp[0] = {1'b0, r_value[3:0]};
    end else begin
      w_fmt_disp[3] = r_value[7] ? SEG_MINUS : SEG_BLANK;
      w_fmt_disp[2] = dec_digit(w_h, w_h == 4'd0);
      w_fmt_disp[1] = dec_digit(w_t, (w_h == 4'd0) && (w_t == 4'd0));
      w_fmt_disp[0] = {1'b0, w_o};
    end
  end

  // All four codes change together so the scanner never sees a mix
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_hex   <= 1'b0;
      r_disp  <= {4{SEG_BLANK}};
    end else begin
      if (w_accept) begin
        r_value <= value;
        r_hex   <= hex_mode;
      end
      if (w_fmt) r_disp <= w_fmt_disp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= '1;
      r_digit <= SEG_BLANK;
    end else begin
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_an    <= ~(4'b0001 << r_idx);
      r_digit <= r_disp[r_idx];
    end
  end

  assign an           = r_an;
  assign digit_holder = r_digit;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a short refresh divider.
module tb_seg_scan_driver;

  localparam int unsigned DIV = 4;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] value    = '0;
  logic       hex_mode = 1'b0;
  logic       load     = 1'b0;
  logic       busy;
  logic [3:0] an;
  logic [4:0] digit_holder;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .hex_mode    (hex_mode),
    .load        (load),
    .busy        (busy),
    .an          (an),
    .digit_holder(digit_holder)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the first negedge with busy low (bounded)
  task automatic do_load(input logic [7:0] v, input logic h, output int cyc);
    value    = v;
    hex_mode = h;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    cyc  = 0;
    while (busy === 1'b1 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Watch a little over one full scan and collect the code shown on each anode
  task automatic read_disp(input string tag, input logic [4:0] e3, input logic [4:0] e2,
                           input logic [4:0] e1, input logic [4:0] e0);
    logic [4:0] got [4];
    int seen = 0;
    int bad  = 0;
    for (int i = 0; i < 4; i++) got[i] = 'x;
    for (int n = 0; n < int'(4*DIV + 4); n++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin got[0] = digit_holder; seen |= 1; end
        4'b1101: begin got[1] = digit_holder; seen |= 2; end
        4'b1011: begin got[2] = digit_holder; seen |= 4; end
        4'b0111: begin got[3] = digit_holder; seen |= 8; end
        default: bad++;
      endcase
    end
    check({tag, ".d3"}, got[3], e3);
    check({tag, ".d2"}, got[2], e2);
    check({tag, ".d1"}, got[1], e1);
    check({tag, ".d0"}, got[0], e0);
    check({tag, ".an_bad"}, bad, 0);
    check({tag, ".an_seen"}, seen, 15);
  endtask

  initial begin
    int cyc;
    int bad16;

    repeat (2) @(negedge clk);
    check("rst.an",   an, 4'b1111);
    check("rst.dh",   digit_holder, 16);
    check("rst.busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel.e1.an", an, 4'b1110);
    check("rel.e1.dh", digit_holder, 16);
    repeat (3) @(posedge clk); #1;
    check("rel.e4.an", an, 4'b1110);
    @(posedge clk); #1;
    check("rel.e5.an", an, 4'b1101);
    @(negedge clk);

    // Reset partway through converting 99
    bad16    = 0;
    value    = 8'd99;
    hex_mode = 1'b0;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) begin
      if (digit_holder !== 5'd16) bad16++;
      @(negedge clk);
    end
    check("rstmid.busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rstmid.busy", busy, 0);
    check("rstmid.an", an, 4'b1111);
    check("rstmid.partial", bad16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    read_disp("rstmid", 16, 16, 16, 16);

    do_load(8'd127, 1'b0, cyc);
    check("d127.busy", cyc, 9);
    read_disp("d127", 16, 1, 2, 7);

    do_load(8'd0, 1'b0, cyc);
    check("d0.busy", cyc, 9);
    read_disp("d0", 16, 16, 16, 0);

    do_load(8'h80, 1'b0, cyc);
    check("dm128.busy", cyc, 9);
    read_disp("dm128", 17, 1, 2, 8);

    do_load(8'hF9, 1'b0, cyc);
    read_disp("dm7", 17, 16, 16, 7);

    do_load(8'hF6, 1'b0, cyc);
    read_disp("dm10", 17, 16, 1, 0);

    do_load(8'hA3, 1'b1, cyc);
    check("hA3.busy", cyc, 1);
    read_disp("hA3", 16, 16, 10, 3);

    // Second load three cycles into a conversion must be dropped
    value    = 8'd127;
    hex_mode = 1'b0;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    value = 8'h05;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("drop.busy_mid", busy, 1);
    cyc = 0;
    while (busy === 1'b1 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check("drop.busy_rest", cyc, 6);
    read_disp("drop", 16, 1, 2, 7);

    // Load on the cycle right after busy falls is taken
    do_load(8'h05, 1'b0, cyc);
    do_load(8'hF6, 1'b0, cyc);
    check("after.busy", cyc, 9);
    read_disp("after", 17, 16, 1, 0);

    // Asynchronous reset mid-scan and mid-conversion
    value    = 8'd127;
    hex_mode = 1'b0;
    load     = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async.an",   an, 4'b1111);
    check("async.dh",   digit_holder, 16);
    check("async.busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("async.e1.an", an, 4'b1110);
    repeat (3) @(posedge clk); #1;
    check("async.e4.an", an, 4'b1110);
    @(posedge clk); #1;
    check("async.e5.an", an, 4'b1101);
    @(negedge clk);
    read_disp("async", 16, 16, 16, 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
